lsu_issue_queue: RTL and testbench

//  Memory-op reservation station directly upstream of the LSU. Holds dispatched loads/stores until

---
 rtl/lsu_issue_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_issue_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue: memory-op reservation station feeding the LSU.
// Holds dispatched loads/stores until their operands arrive on the write-back
// broadcast ports, then issues one ready op per cycle, oldest first, through
// registered outputs.
module lsu_issue_queue #(
    parameter int RS_LEN  = 4,
    parameter int ROB_LEN = 16,
    parameter int LQ_LEN  = 4,
    parameter int SQ_LEN  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dis_valid,
    input  logic                         dis_is_store,
    input  logic [6:0]                   dis_rs1_tag,
    input  logic                         dis_rs1_rdy,
    input  logic [31:0]                  dis_rs1_data,
    input  logic [6:0]                   dis_rs2_tag,
    input  logic                         dis_rs2_rdy,
    input  logic [31:0]                  dis_rs2_data,
    input  logic [31:0]                  dis_imm,
    input  logic [2:0]                   dis_funct3,
    input  logic [$clog2(ROB_LEN)-1:0]   dis_rob_idx,
    input  logic [$clog2(LQ_LEN):0]      dis_ld_idx,
    input  logic [$clog2(SQ_LEN):0]      dis_st_idx,
    output logic                         rs_ready,
    input  logic                         wb0_valid,
    input  logic [6:0]                   wb0_tag,
    input  logic [31:0]                  wb0_data,
    input  logic                         wb1_valid,
    input  logic [6:0]                   wb1_tag,
    input  logic [31:0]                  wb1_data,
    input  logic                         mispredict,
    input  logic [ROB_LEN-1:0]           flush_mask,
    output logic                         ld_i_valid,
    output logic                         st_i_valid,
    output logic [31:0]                  lsu_i_rs1_data,
    output logic [31:0]                  lsu_i_rs2_data,
    output logic [31:0]                  lsu_i_imm,
    output logic [2:0]                   funct3,
    output logic [$clog2(ROB_LEN)-1:0]   lsu_i_rob_idx,
    output logic [$clog2(LQ_LEN):0]      EX_ld_idx,
    output logic [$clog2(SQ_LEN):0]      EX_st_idx
);

    localparam int IW = $clog2(RS_LEN);
    localparam int RW = $clog2(ROB_LEN);
    localparam int LW = $clog2(LQ_LEN) + 1;
    localparam int SW = $clog2(SQ_LEN) + 1;

    typedef struct packed {
        logic          valid;
        logic          is_store;
        logic [6:0]    rs1_tag;
        logic          rs1_rdy;
        logic [31:0]   rs1_data;
        logic [6:0]    rs2_tag;
        logic          rs2_rdy;
        logic [31:0]   rs2_data;
        logic [31:0]   imm;
        logic [2:0]    f3;
        logic [RW-1:0] rob_idx;
        logic [LW-1:0] ld_idx;
        logic [SW-1:0] st_idx;
    } entry_t;

    entry_t            ent_q   [RS_LEN];
    entry_t            ent_d   [RS_LEN];
    // older_q[i][j] = 1 when entry i was allocated before entry j
    logic [RS_LEN-1:0] older_q [RS_LEN];
    logic [RS_LEN-1:0] older_d [RS_LEN];

    logic [RS_LEN-1:0] valid_vec;
    logic [RS_LEN-1:0] req_vec;
    logic [RS_LEN-1:0] flush_vec;
    logic [RS_LEN-1:0] sel_oh;
    logic [IW-1:0]     alloc_idx;
    logic [IW-1:0]     sel_idx;
    logic              sel_any;
    logic              dis_fire;
    logic              issue_fire;

    // Operand resolution shared by dispatch and wakeup: x0 is always ready with
    // value 0; otherwise a not-ready operand captures a matching broadcast.
    function automatic logic [32:0] snoop(input logic [6:0] tag, input logic rdy,
                                          input logic [31:0] data);
        logic [32:0] res;
        res = {rdy, data};
        if (!rdy) begin
            if (tag == 7'd0)
                res = {1'b1, 32'd0};
            else if (wb0_valid && wb0_tag == tag)
                res = {1'b1, wb0_data};
            else if (wb1_valid && wb1_tag == tag)
                res = {1'b1, wb1_data};
        end
        return res;
    endfunction

    // Per-entry status vectors, free-slot search and dispatch acceptance
    always_comb begin
        for (int unsigned i = 0; i < RS_LEN; i++) begin
            valid_vec[i] = ent_q[i].valid;
            req_vec[i]   = ent_q[i].valid && ent_q[i].rs1_rdy &&
                           (!ent_q[i].is_store || ent_q[i].rs2_rdy);
            flush_vec[i] = ent_q[i].valid && mispredict && flush_mask[ent_q[i].rob_idx];
        end
        alloc_idx = '0;
        for (int unsigned i = RS_LEN; i > 0; i--) begin
            if (!valid_vec[i-1])
                alloc_idx = IW'(i - 1);
        end
        rs_ready = |(~valid_vec);
        dis_fire = dis_valid && rs_ready && !mispredict;
    end

    // Oldest-ready select: a requester wins if no older entry is also requesting
    always_comb begin
        logic blocked;
        sel_oh  = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < RS_LEN; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < RS_LEN; j++) begin
                if (j != i && req_vec[j] && older_q[j][i])
                    blocked = 1'b1;
            end
            sel_oh[i] = req_vec[i] && !blocked;
        end
        for (int unsigned i = RS_LEN; i > 0; i--) begin
            if (sel_oh[i-1])
                sel_idx = IW'(i - 1);
        end
        sel_any    = |sel_oh;
        issue_fire = sel_any && !flush_vec[sel_idx];
    end

    // Next entry state: wakeup, free on issue/flush, allocate on dispatch
    always_comb begin
        ent_d   = ent_q;
        older_d = older_q;
        for (int unsigned i = 0; i < RS_LEN; i++) begin
            if (ent_q[i].valid) begin
                {ent_d[i].rs1_rdy, ent_d[i].rs1_data} =
                    snoop(ent_q[i].rs1_tag, ent_q[i].rs1_rdy, ent_q[i].rs1_data);
                {ent_d[i].rs2_rdy, ent_d[i].rs2_data} =
                    snoop(ent_q[i].rs2_tag, ent_q[i].rs2_rdy, ent_q[i].rs2_data);
                if (flush_vec[i] || (sel_oh[i] && sel_any))
                    ent_d[i].valid = 1'b0;
            end
        end
        if (dis_fire) begin
            ent_d[alloc_idx].valid    = 1'b1;
            ent_d[alloc_idx].is_store = dis_is_store;
            ent_d[alloc_idx].rs1_tag  = dis_rs1_tag;
            {ent_d[alloc_idx].rs1_rdy, ent_d[alloc_idx].rs1_data} =
                snoop(dis_rs1_tag, dis_rs1_rdy, dis_rs1_data);
            // Loads carry rs2 as a ready zero so the store-data output reads 0
            if (dis_is_store) begin
                ent_d[alloc_idx].rs2_tag = dis_rs2_tag;
                {ent_d[alloc_idx].rs2_rdy, ent_d[alloc_idx].rs2_data} =
                    snoop(dis_rs2_tag, dis_rs2_rdy, dis_rs2_data);
            end else begin
                ent_d[alloc_idx].rs2_tag  = 7'd0;
                ent_d[alloc_idx].rs2_rdy  = 1'b1;
                ent_d[alloc_idx].rs2_data = 32'd0;
            end
            ent_d[alloc_idx].imm     = dis_imm;
            ent_d[alloc_idx].f3      = dis_funct3;
            ent_d[alloc_idx].rob_idx = dis_rob_idx;
            ent_d[alloc_idx].ld_idx  = dis_ld_idx;
            ent_d[alloc_idx].st_idx  = dis_st_idx;
            // New entry is younger than every entry currently held
            older_d[alloc_idx] = '0;
            for (int unsigned j = 0; j < RS_LEN; j++)
                older_d[j][alloc_idx] = valid_vec[j];
        end
    end

    // Entry and age-matrix registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RS_LEN; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < RS_LEN; i++) begin
                ent_q[i]   <= ent_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

    // Registered issue port; payload holds when nothing issues
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_i_valid     <= 1'b0;
            st_i_valid     <= 1'b0;
            lsu_i_rs1_data <= '0;
            lsu_i_rs2_data <= '0;
            lsu_i_imm      <= '0;
            funct3         <= '0;
            lsu_i_rob_idx  <= '0;
            EX_ld_idx      <= '0;
            EX_st_idx      <= '0;
        end else if (issue_fire) begin
            ld_i_valid     <= !ent_q[sel_idx].is_store;
            st_i_valid     <= ent_q[sel_idx].is_store;
            lsu_i_rs1_data <= ent_q[sel_idx].rs1_data;
            lsu_i_rs2_data <= ent_q[sel_idx].rs2_data;
            lsu_i_imm      <= ent_q[sel_idx].imm;
            funct3         <= ent_q[sel_idx].f3;
            lsu_i_rob_idx  <= ent_q[sel_idx].rob_idx;
            EX_ld_idx      <= ent_q[sel_idx].ld_idx;
            EX_st_idx      <= ent_q[sel_idx].st_idx;
        end else begin
            ld_i_valid <= 1'b0;
            st_i_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Self-checking bench for lsu_issue_queue: table-driven ready ops plus
// hand-written multi-cycle sequences; issued ops are checked by a scoreboard.
module tb_lsu_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        dis_valid, dis_is_store;
    logic [6:0]  dis_rs1_tag, dis_rs2_tag;
    logic        dis_rs1_rdy, dis_rs2_rdy;
    logic [31:0] dis_rs1_data, dis_rs2_data, dis_imm;
    logic [2:0]  dis_funct3;
    logic [3:0]  dis_rob_idx;
    logic [2:0]  dis_ld_idx, dis_st_idx;
    logic        rs_ready;
    logic        wb0_valid, wb1_valid;
    logic [6:0]  wb0_tag, wb1_tag;
    logic [31:0] wb0_data, wb1_data;
    logic        mispredict;
    logic [15:0] flush_mask;
    logic        ld_i_valid, st_i_valid;
    logic [31:0] lsu_i_rs1_data, lsu_i_rs2_data, lsu_i_imm;
    logic [2:0]  funct3;
    logic [3:0]  lsu_i_rob_idx;
    logic [2:0]  EX_ld_idx, EX_st_idx;

    always #5 clk = ~clk;

    lsu_issue_queue #(.RS_LEN(4), .ROB_LEN(16), .LQ_LEN(4), .SQ_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .dis_valid(dis_valid), .dis_is_store(dis_is_store),
        .dis_rs1_tag(dis_rs1_tag), .dis_rs1_rdy(dis_rs1_rdy), .dis_rs1_data(dis_rs1_data),
        .dis_rs2_tag(dis_rs2_tag), .dis_rs2_rdy(dis_rs2_rdy), .dis_rs2_data(dis_rs2_data),
        .dis_imm(dis_imm), .dis_funct3(dis_funct3), .dis_rob_idx(dis_rob_idx),
        .dis_ld_idx(dis_ld_idx), .dis_st_idx(dis_st_idx), .rs_ready(rs_ready),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
        .mispredict(mispredict), .flush_mask(flush_mask),
        .ld_i_valid(ld_i_valid), .st_i_valid(st_i_valid),
        .lsu_i_rs1_data(lsu_i_rs1_data), .lsu_i_rs2_data(lsu_i_rs2_data),
        .lsu_i_imm(lsu_i_imm), .funct3(funct3), .lsu_i_rob_idx(lsu_i_rob_idx),
        .EX_ld_idx(EX_ld_idx), .EX_st_idx(EX_st_idx)
    );

    typedef struct packed {
        logic        is_st;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  rob;
        logic [2:0]  ld;
        logic [2:0]  st;
    } iss_t;

    typedef struct {
        logic        st;
        logic [6:0]  t1;
        logic        r1;
        logic [31:0] d1;
        logic [6:0]  t2;
        logic        r2;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  rob;
        logic [2:0]  ld;
        logic [2:0]  sti;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
    } vec_t;

    iss_t sb[$];
    iss_t got;
    iss_t exp_r;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every issue pulse must match the oldest expected op
    always @(negedge clk) begin
        if (rst === 1'b1 && (ld_i_valid || st_i_valid)) begin
            got.is_st = st_i_valid;
            got.rs1   = lsu_i_rs1_data;
            got.rs2   = lsu_i_rs2_data;
            got.imm   = lsu_i_imm;
            got.f3    = funct3;
            got.rob   = lsu_i_rob_idx;
            got.ld    = EX_ld_idx;
            got.st    = EX_st_idx;
            chk("issue_kind", {127'd0, ld_i_valid ^ st_i_valid}, 128'd1);
            if (sb.size() == 0) begin
                chk("unexpected_issue", {18'd0, got}, 128'd0);
            end else begin
                exp_r = sb.pop_front();
                chk("issue", {18'd0, got}, {18'd0, exp_r});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dis_valid  = 1'b0;
        wb0_valid  = 1'b0;
        wb1_valid  = 1'b0;
        mispredict = 1'b0;
        flush_mask = '0;
    endtask

    task automatic drive_dis(input logic st, input logic [6:0] t1, input logic r1,
                             input logic [31:0] d1, input logic [6:0] t2, input logic r2,
                             input logic [31:0] d2, input logic [31:0] imm,
                             input logic [2:0] f3, input logic [3:0] rob,
                             input logic [2:0] ld, input logic [2:0] sti);
        dis_valid    = 1'b1;
        dis_is_store = st;
        dis_rs1_tag  = t1;  dis_rs1_rdy = r1;  dis_rs1_data = d1;
        dis_rs2_tag  = t2;  dis_rs2_rdy = r2;  dis_rs2_data = d2;
        dis_imm      = imm; dis_funct3  = f3;  dis_rob_idx  = rob;
        dis_ld_idx   = ld;  dis_st_idx  = sti;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles && sb.size() != 0; c++)
            step();
        chk("drain", 128'(sb.size()), 128'd0);
        sb.delete();
        repeat (3) step();
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle();
        drive_dis(1'b0, 7'd0, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 3'd0, 3'd0);
        dis_valid = 1'b0;
        step(); step();
        chk("reset_rs_ready", 128'(rs_ready), 128'd1);
        chk("reset_ld_valid", 128'(ld_i_valid), 128'd0);
        chk("reset_st_valid", 128'(st_i_valid), 128'd0);
        chk("reset_rs1", 128'(lsu_i_rs1_data), 128'd0);
        rst = 1'b1;
        step();

        // Table: ready ops dispatched back-to-back, including x0 operands
        vecs[0] = '{1'b0, 7'd5,   1'b1, 32'h0000_1000, 7'd0,   1'b0, 32'h55,
                    32'd4, 3'd2, 4'd1, 3'd1, 3'd0, 32'h0000_1000, 32'd0};
        vecs[1] = '{1'b1, 7'd6,   1'b1, 32'h0000_2000, 7'd7,   1'b1, 32'h1234_5678,
                    32'hFFFF_FFFC, 3'd2, 4'd2, 3'd1, 3'd3, 32'h0000_2000, 32'h1234_5678};
        vecs[2] = '{1'b0, 7'd0,   1'b0, 32'h0000_0BAD, 7'd0,   1'b0, 32'd0,
                    32'h10, 3'd4, 4'd3, 3'd2, 3'd3, 32'd0, 32'd0};
        vecs[3] = '{1'b1, 7'd0,   1'b0, 32'h0000_0BAD, 7'd0,   1'b0, 32'hBEEF,
                    32'd0, 3'd0, 4'd15, 3'd7, 3'd7, 32'd0, 32'd0};
        vecs[4] = '{1'b0, 7'd127, 1'b1, 32'hFFFF_FFFF, 7'd3,   1'b1, 32'h77,
                    32'h7FF, 3'd5, 4'd0, 3'd7, 3'd4, 32'hFFFF_FFFF, 32'd0};
        vecs[5] = '{1'b1, 7'd8,   1'b1, 32'h8000_0000, 7'd127, 1'b1, 32'hFFFF_FFFF,
                    32'h800, 3'd1, 4'd14, 3'd0, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            drive_dis(vecs[i].st, vecs[i].t1, vecs[i].r1, vecs[i].d1, vecs[i].t2,
                      vecs[i].r2, vecs[i].d2, vecs[i].imm, vecs[i].f3, vecs[i].rob,
                      vecs[i].ld, vecs[i].sti);
            sb.push_back('{vecs[i].st, vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].imm,
                           vecs[i].f3, vecs[i].rob, vecs[i].ld, vecs[i].sti});
            step();
        end
        idle();
        wait_drain(20);

        // Ready load: issue visible two cycles after dispatch, for one cycle only
        drive_dis(1'b0, 7'd5, 1'b1, 32'h1000, 7'd0, 1'b0, 32'd0, 32'd4, 3'd2, 4'd4, 3'd2, 3'd1);
        sb.push_back('{1'b0, 32'h1000, 32'd0, 32'd4, 3'd2, 4'd4, 3'd2, 3'd1});
        step(); idle();
        chk("t1_not_early", 128'(ld_i_valid), 128'd0);
        step();
        chk("t1_ld_valid", 128'(ld_i_valid), 128'd1);
        chk("t1_rs1", 128'(lsu_i_rs1_data), 128'h1000);
        chk("t1_imm", 128'(lsu_i_imm), 128'd4);
        step();
        chk("t1_one_cycle", 128'(ld_i_valid), 128'd0);
        chk("t1_hold", 128'(lsu_i_rs1_data), 128'h1000);
        wait_drain(5);

        // Store waits for rs2 via wb1 in cycle 3; issues in cycle 5
        drive_dis(1'b1, 7'd3, 1'b1, 32'h2000, 7'd9, 1'b0, 32'd0, 32'd8, 3'd2, 4'd5, 3'd2, 3'd2);
        sb.push_back('{1'b1, 32'h2000, 32'hDEAD, 32'd8, 3'd2, 4'd5, 3'd2, 3'd2});
        step(); idle();
        step(); step();
        wb1_valid = 1'b1; wb1_tag = 7'd9; wb1_data = 32'hDEAD;
        step(); idle();
        chk("t2_not_early", 128'(st_i_valid), 128'd0);
        step();
        chk("t2_st_valid", 128'(st_i_valid), 128'd1);
        chk("t2_rs2", 128'(lsu_i_rs2_data), 128'hDEAD);
        wait_drain(5);

        // Fill all entries, refuse a fifth dispatch even while the first issues
        for (int i = 0; i < 4; i++) begin
            drive_dis(i[0], 7'd30, 1'b0, 32'd0, 7'd0, 1'b1, 32'h100 + 32'(i),
                      32'h40 + 32'(i), 3'(i), 4'(6 + i), 3'(i), 3'(i));
            sb.push_back('{i[0], 32'h3333_0000, i[0] ? 32'h100 + 32'(i) : 32'd0,
                           32'h40 + 32'(i), 3'(i), 4'(6 + i), 3'(i), 3'(i)});
            step();
        end
        idle();
        chk("t3_full", 128'(rs_ready), 128'd0);
        drive_dis(1'b0, 7'd2, 1'b1, 32'h9999, 7'd0, 1'b0, 32'd0, 32'h99, 3'd0, 4'd15, 3'd0, 3'd0);
        wb0_valid = 1'b1; wb0_tag = 7'd30; wb0_data = 32'h3333_0000;
        step();
        wb0_valid = 1'b0;
        chk("t3_full_at_select", 128'(rs_ready), 128'd0);
        step(); idle();
        chk("t3_freed", 128'(rs_ready), 128'd1);
        wait_drain(10);

        // Same-cycle wakeup at dispatch
        drive_dis(1'b0, 7'd12, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 32'h20, 3'd0, 4'd9, 3'd3, 3'd0);
        wb0_valid = 1'b1; wb0_tag = 7'd12; wb0_data = 32'hCAFE;
        sb.push_back('{1'b0, 32'hCAFE, 32'd0, 32'h20, 3'd0, 4'd9, 3'd3, 3'd0});
        step(); idle();
        chk("t4_not_early", 128'(ld_i_valid), 128'd0);
        step();
        chk("t4_issue", 128'(ld_i_valid), 128'd1);
        wait_drain(5);

        // Mispredict flushes rob 6,7; drops same-cycle dispatch; survivors keep age
        drive_dis(1'b0, 7'd40, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 32'h6, 3'd0, 4'd6, 3'd0, 3'd0);
        step();
        drive_dis(1'b1, 7'd40, 1'b0, 32'd0, 7'd0, 1'b1, 32'hABC, 32'h5, 3'd1, 4'd5, 3'd1, 3'd1);
        step();
        drive_dis(1'b0, 7'd40, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 32'h7, 3'd0, 4'd7, 3'd2, 3'd2);
        step();
        drive_dis(1'b0, 7'd2, 1'b1, 32'h8888, 7'd0, 1'b0, 32'd0, 32'h8, 3'd0, 4'd8, 3'd3, 3'd3);
        mispredict = 1'b1; flush_mask = 16'h00C0;
        step(); idle();
        drive_dis(1'b0, 7'd40, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 32'hB, 3'd3, 4'd11, 3'd4, 3'd4);
        step(); idle();
        sb.push_back('{1'b1, 32'h5555, 32'hABC, 32'h5, 3'd1, 4'd5, 3'd1, 3'd1});
        sb.push_back('{1'b0, 32'h5555, 32'd0, 32'hB, 3'd3, 4'd11, 3'd4, 3'd4});
        wb0_valid = 1'b1; wb0_tag = 7'd40; wb0_data = 32'h5555;
        step(); idle();
        wait_drain(10);

        // A selection whose rob slot is flushed that cycle must not issue
        drive_dis(1'b0, 7'd2, 1'b1, 32'h1010, 7'd0, 1'b0, 32'd0, 32'h10, 3'd0, 4'd10, 3'd0, 3'd0);
        step(); idle();
        mispredict = 1'b1; flush_mask = 16'h0400;
        step(); idle();
        chk("t5_flushed_select", 128'(ld_i_valid | st_i_valid), 128'd0);
        chk("t5_entry_freed", 128'(rs_ready), 128'd1);
        repeat (3) step();

        // Reset mid-operation clears held outputs and pending entries
        drive_dis(1'b0, 7'd2, 1'b1, 32'hABCD_0000, 7'd0, 1'b0, 32'd0, 32'h44, 3'd2, 4'd12, 3'd1, 3'd1);
        sb.push_back('{1'b0, 32'hABCD_0000, 32'd0, 32'h44, 3'd2, 4'd12, 3'd1, 3'd1});
        step();
        drive_dis(1'b0, 7'd20, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 32'h1, 3'd0, 4'd13, 3'd2, 3'd2);
        step();
        drive_dis(1'b1, 7'd20, 1'b0, 32'd0, 7'd20, 1'b0, 32'd0, 32'h2, 3'd0, 4'd14, 3'd3, 3'd3);
        step(); idle();
        chk("t6_pre_hold", 128'(lsu_i_rs1_data), 128'hABCD_0000);
        rst = 1'b0;
        #1;
        chk("t6_rs1_cleared", 128'(lsu_i_rs1_data), 128'd0);
        chk("t6_imm_cleared", 128'(lsu_i_imm), 128'd0);
        chk("t6_valid_cleared", 128'(ld_i_valid | st_i_valid), 128'd0);
        chk("t6_rs_ready", 128'(rs_ready), 128'd1);
        sb.delete();
        step();
        rst = 1'b1;
        wb0_valid = 1'b1; wb0_tag = 7'd20; wb0_data = 32'h2020;
        step(); idle();
        repeat (4) step();
        chk("t6_nothing_issued", 128'(ld_i_valid | st_i_valid), 128'd0);
        chk("t6_empty", 128'(rs_ready), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
